// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD add: binary add, then +6 correction on decimal carry.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_t a,
  input  bcd_t b,
  input  logic cin,
  output bcd_t s,
  output logic cout
);

  logic [4:0] w_z;

  assign w_z  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
  assign cout = w_z[4] | (w_z[3] & w_z[2]) | (w_z[3] & w_z[1]);
  // 4-bit add wraps, giving the mod-16 correction
  assign s    = cout ? (w_z[3:0] + BCD_CORR) : w_z[3:0];

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder: one digit pair per clock, LSD first,
// with valid/ready handshakes on operands and result.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   augend,
  input  logic [4*DIGITS-1:0]   addend,
  input  logic                  carry_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry_out,
  output logic                  digit_err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic [W-1:0]    w_shift;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic            r_cout;
  logic            r_err;
  logic            w_err;
  logic            w_accept;
  logic            w_last;
  bcd_t            w_s;
  logic            w_dc;

  bcd_digit_add u_dig (
    .a    (r_a[3:0]),
    .b    (r_b[3:0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_dc)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign digit_err = r_err;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == LAST);

  always_comb begin
    w_err = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (augend[4*k +: 4] > BCD_MAX) w_err = 1'b1;
      if (addend[4*k +: 4] > BCD_MAX) w_err = 1'b1;
    end
  end

  // New digit enters at the top; after DIGITS shifts digit k sits at 4k
  always_comb begin
    w_shift          = r_sum >> 4;
    w_shift[W-1 -: 4] = w_s;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_a     <= augend;
        r_b     <= addend;
        r_carry <= carry_in;
        r_sum   <= '0;
        r_cnt   <= '0;
        r_cout  <= 1'b0;
        r_err   <= w_err;
      end
    end else if (r_state == RUN) begin
      r_sum   <= w_shift;
      r_a     <= r_a >> 4;
      r_b     <= r_b >> 4;
      r_carry <= w_dc;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) r_cout <= w_dc;
    end
  end

endmodule
